// File: rtl/qsfp_i2c_cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// qsfp_i2c_cmd_arbiter_if
//
// Bundles the requester-facing and sequencer-facing signals of the QSFP I2C
// command arbiter.
//
//   req_valid/req_rw/req_id/req_addr/req_wdata : requester i fields, byte
//                                                lanes at [8i+7:8i]
//   req_done/req_err/req_rdata                 : completion back to requesters
//   cmd_pulse/cmd_rw/cmd_id/cmd_addr/cmd_wdata : command to the sequencer
//   cmd_cmplt/cmd_rdata                        : completion from the sequencer
//
// Modports:
//   slave  : the arbiter itself (consumes requests, drives the command port)
//   master : the environment (requesters plus the byte-level sequencer)
//
// Handshake: a requester raises req_valid with its fields stable and keeps it
// high until it sees its own bit of req_done. The arbiter treats cmd_pulse
// as a single-cycle start. The sequencer answers with a single-cycle
// cmd_cmplt that carries cmd_rdata. There is no backpressure on either side.
// ---------------------------------------------------------------------------
interface qsfp_i2c_cmd_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_rw;
    logic [NUM_REQ*8-1:0] req_id;
    logic [NUM_REQ*8-1:0] req_addr;
    logic [NUM_REQ*8-1:0] req_wdata;
    logic [NUM_REQ-1:0]   req_done;
    logic                 req_err;
    logic [7:0]           req_rdata;

    logic                 cmd_pulse;
    logic                 cmd_rw;
    logic [7:0]           cmd_id;
    logic [7:0]           cmd_addr;
    logic [7:0]           cmd_wdata;
    logic                 cmd_cmplt;
    logic [7:0]           cmd_rdata;

    modport slave (
        input  req_valid, req_rw, req_id, req_addr, req_wdata,
        input  cmd_cmplt, cmd_rdata,
        output req_done, req_err, req_rdata,
        output cmd_pulse, cmd_rw, cmd_id, cmd_addr, cmd_wdata
    );

    modport master (
        output req_valid, req_rw, req_id, req_addr, req_wdata,
        output cmd_cmplt, cmd_rdata,
        input  req_done, req_err, req_rdata,
        input  cmd_pulse, cmd_rw, cmd_id, cmd_addr, cmd_wdata
    );
endinterface

// File: rtl/qsfp_i2c_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// qsfp_i2c_cmd_arbiter
//
// Round-robin arbiter that shares the byte-level I2C command port of the QSFP
// I2C AXI sequencer between NUM_REQ requesters. One command is in flight at a
// time. The winner's fields are latched, a one-cycle cmd_pulse is issued, and
// the arbiter waits for cmd_cmplt. It then returns the result with a
// one-cycle req_done. A completion timeout aborts a hung transfer.
//
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   bus          : requester + sequencer signals (slave modport)
//   busy         : high in every state except IDLE
//   grant_idx    : index of the current/last granted requester
//   timeout_cnt  : saturating count of timed-out commands
//   state_dbg    : current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE)
//
// Every output is a register. cmd_pulse is high during the ISSUE cycle.
// req_done is high during the DONE cycle.
// ---------------------------------------------------------------------------
module qsfp_i2c_cmd_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                       clk,
    input  logic                       rst,
    qsfp_i2c_cmd_arbiter_if.slave      bus,
    output logic                       busy,
    output logic [2:0]                 grant_idx,
    output logic [7:0]                 timeout_cnt,
    output logic [1:0]                 state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    arb_state_e         state;
    arb_state_e         state_nxt;
    logic [2:0]         rr_ptr;
    logic [NUM_REQ-1:0] mask;
    logic [23:0]        timer;

    logic [7:0]         eligible;
    logic [3:0]         cand;
    logic               pick_found;
    logic [2:0]         pick_idx;
    logic               sel_rw;
    logic [7:0]         sel_id;
    logic [7:0]         sel_addr;
    logic [7:0]         sel_wdata;
    logic [NUM_REQ-1:0] grant_vec;
    logic               timer_expired;

    assign state_dbg     = state;
    assign timer_expired = (timer == 24'(TIMEOUT_CYCLES - 1));

    // Round-robin pick: scan upward from rr_ptr+1 and wrap at NUM_REQ. The
    // requester just served is masked for one IDLE cycle so that a late
    // req_valid drop cannot win it a second turn.
    always_comb begin
        eligible               = '0;
        eligible[NUM_REQ-1:0]  = bus.req_valid & ~mask;
        cand                   = '0;
        pick_found             = 1'b0;
        pick_idx               = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!pick_found && eligible[cand[2:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[2:0];
            end
        end
    end

    // Field mux for the picked requester, and a one-hot of the current grant.
    always_comb begin
        sel_rw    = 1'b0;
        sel_id    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        grant_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == pick_idx) begin
                sel_rw    = bus.req_rw[i];
                sel_id    = bus.req_id[8*i +: 8];
                sel_addr  = bus.req_addr[8*i +: 8];
                sel_wdata = bus.req_wdata[8*i +: 8];
            end
            if (3'(i) == grant_idx) begin
                grant_vec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (bus.cmd_cmplt || timer_expired) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= 3'(NUM_REQ - 1);
            mask          <= '0;
            timer         <= '0;
            busy          <= 1'b0;
            grant_idx     <= '0;
            timeout_cnt   <= '0;
            bus.req_done  <= '0;
            bus.req_err   <= 1'b0;
            bus.req_rdata <= '0;
            bus.cmd_pulse <= 1'b0;
            bus.cmd_rw    <= 1'b0;
            bus.cmd_id    <= '0;
            bus.cmd_addr  <= '0;
            bus.cmd_wdata <= '0;
        end else begin
            state         <= state_nxt;
            busy          <= (state_nxt != IDLE);
            bus.cmd_pulse <= (state_nxt == ISSUE);
            bus.req_done  <= '0;
            case (state)
                IDLE: begin
                    mask <= '0;
                    if (pick_found) begin
                        bus.cmd_rw    <= sel_rw;
                        bus.cmd_id    <= sel_id;
                        bus.cmd_addr  <= sel_addr;
                        bus.cmd_wdata <= sel_wdata;
                        grant_idx     <= pick_idx;
                        rr_ptr        <= pick_idx;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                end
                WAIT: begin
                    timer <= timer + 24'd1;
                    // A completion arriving in the timeout cycle is honoured.
                    if (bus.cmd_cmplt) begin
                        bus.req_rdata <= bus.cmd_rw ? bus.cmd_rdata : 8'h00;
                        bus.req_err   <= 1'b0;
                        bus.req_done  <= grant_vec;
                    end else if (timer_expired) begin
                        bus.req_rdata <= 8'h00;
                        bus.req_err   <= 1'b1;
                        bus.req_done  <= grant_vec;
                        if (timeout_cnt != 8'hFF) begin
                            timeout_cnt <= timeout_cnt + 8'd1;
                        end
                    end
                end
                DONE: begin
                    mask <= grant_vec;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qsfp_i2c_cmd_arbiter.sv
module tb_qsfp_i2c_cmd_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [2:0] grant_idx;
    logic [7:0] timeout_cnt;
    logic [1:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;
    int pulse_count = 0;

    qsfp_i2c_cmd_arbiter_if #(.NUM_REQ(NUM_REQ)) bus_if ();

    qsfp_i2c_cmd_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .busy        (busy),
        .grant_idx   (grant_idx),
        .timeout_cnt (timeout_cnt),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.cmd_pulse === 1'b1) pulse_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic clear_inputs();
        bus_if.req_valid = '0;
        bus_if.req_rw    = '0;
        bus_if.req_id    = '0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        bus_if.cmd_cmplt = 1'b0;
        bus_if.cmd_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic rw, input logic [7:0] id,
                           input logic [7:0] addr, input logic [7:0] wdata);
        bus_if.req_rw[i]          = rw;
        bus_if.req_id[8*i +: 8]    = id;
        bus_if.req_addr[8*i +: 8]  = addr;
        bus_if.req_wdata[8*i +: 8] = wdata;
    endtask

    // Called at a negedge; returns at the negedge where cmd_pulse is seen.
    task automatic wait_pulse(output bit ok, input int max_cycles);
        ok = 1'b0;
        for (int k = 0; k < max_cycles; k++) begin
            if (bus_if.cmd_pulse === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called at the pulse negedge. It raises cmd_cmplt d cycles later and
    // returns at the following negedge, the cycle in which req_done shows.
    task automatic serve(input int d, input logic [7:0] rd);
        repeat (d) @(negedge clk);
        bus_if.cmd_cmplt = 1'b1;
        bus_if.cmd_rdata = rd;
        @(negedge clk);
        bus_if.cmd_cmplt = 1'b0;
    endtask

    // tests
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus_if.req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        n_vec++; if (bus_if.cmd_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse: got %b want 0", bus_if.cmd_pulse); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (bus_if.req_done !== 4'b0000) begin n_err++; $display("FAIL reset_done: got %b want 0000", bus_if.req_done); end
        n_vec++; if ({bus_if.req_err, bus_if.req_rdata} !== 9'h000) begin n_err++; $display("FAIL reset_result: got %h want 000", {bus_if.req_err, bus_if.req_rdata}); end
        n_vec++; if ({bus_if.cmd_rw, bus_if.cmd_id, bus_if.cmd_addr, bus_if.cmd_wdata} !== 25'h0) begin n_err++; $display("FAIL reset_cmd: got %h want 0", {bus_if.cmd_rw, bus_if.cmd_id, bus_if.cmd_addr, bus_if.cmd_wdata}); end
        n_vec++; if (grant_idx !== 3'd0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", grant_idx); end
        n_vec++; if (timeout_cnt !== 8'd0) begin n_err++; $display("FAIL reset_tocnt: got %0d want 0", timeout_cnt); end
        n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        bus_if.req_valid = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_write();
        bit ok;
        int pc0;
        set_req(0, 1'b1, 8'h11, 8'h22, 8'h33);
        set_req(2, 1'b0, 8'hE0, 8'h00, 8'h04);
        bus_if.cmd_rdata = 8'h77;
        pc0 = pulse_count;
        bus_if.req_valid[2] = 1'b1;
        wait_pulse(ok, 8);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL wr_pulse: got none want pulse"); end
        n_vec++; if (grant_idx !== 3'd2) begin n_err++; $display("FAIL wr_grant: got %0d want 2", grant_idx); end
        n_vec++; if ({bus_if.cmd_rw, bus_if.cmd_id, bus_if.cmd_addr, bus_if.cmd_wdata} !== {1'b0, 8'hE0, 8'h00, 8'h04}) begin n_err++; $display("FAIL wr_cmd: got %h want %h", {bus_if.cmd_rw, bus_if.cmd_id, bus_if.cmd_addr, bus_if.cmd_wdata}, {1'b0, 8'hE0, 8'h00, 8'h04}); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b want 1", busy); end
        // requester may change its fields after the grant
        set_req(2, 1'b1, 8'h5C, 8'h5D, 8'h5E);
        serve(10, 8'h77);
        n_vec++; if (bus_if.req_done !== 4'b0100) begin n_err++; $display("FAIL wr_done: got %b want 0100", bus_if.req_done); end
        n_vec++; if ({bus_if.req_err, bus_if.req_rdata} !== 9'h000) begin n_err++; $display("FAIL wr_result: got %h want 000", {bus_if.req_err, bus_if.req_rdata}); end
        n_vec++; if (bus_if.cmd_id !== 8'hE0) begin n_err++; $display("FAIL wr_cmd_hold: got %h want e0", bus_if.cmd_id); end
        @(negedge clk);
        n_vec++; if (bus_if.req_done !== 4'b0000) begin n_err++; $display("FAIL wr_done_width: got %b want 0000", bus_if.req_done); end
        @(negedge clk);
        bus_if.req_valid[2] = 1'b0;  // one cycle late
        repeat (8) @(negedge clk);
        n_vec++; if (pulse_count - pc0 !== 1) begin n_err++; $display("FAIL wr_pulse_count: got %0d want 1", pulse_count - pc0); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_read();
        bit ok;
        set_req(0, 1'b1, 8'hA0, 8'h03, 8'hFF);
        bus_if.cmd_rdata = 8'h00;
        bus_if.req_valid[0] = 1'b1;
        wait_pulse(ok, 8);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL rd_pulse: got none want pulse"); end
        n_vec++; if ({grant_idx, bus_if.cmd_rw, bus_if.cmd_addr} !== {3'd0, 1'b1, 8'h03}) begin n_err++; $display("FAIL rd_cmd: got %h want %h", {grant_idx, bus_if.cmd_rw, bus_if.cmd_addr}, {3'd0, 1'b1, 8'h03}); end
        serve(3, 8'hA5);
        bus_if.req_valid[0] = 1'b0;
        n_vec++; if (bus_if.req_done !== 4'b0001) begin n_err++; $display("FAIL rd_done: got %b want 0001", bus_if.req_done); end
        n_vec++; if ({bus_if.req_err, bus_if.req_rdata} !== {1'b0, 8'hA5}) begin n_err++; $display("FAIL rd_result: got %h want 0a5", {bus_if.req_err, bus_if.req_rdata}); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_done;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'h10 + 8'(i), 8'h40 + 8'(i), 8'h00);
        bus_if.req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_pulse(ok, 8);
            n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL rr_pulse%0d: got none want pulse", g); end
            n_vec++; if (grant_idx !== 3'(exp_order[g])) begin n_err++; $display("FAIL rr_grant%0d: got %0d want %0d", g, grant_idx, exp_order[g]); end
            n_vec++; if (bus_if.cmd_id !== 8'h10 + 8'(exp_order[g])) begin n_err++; $display("FAIL rr_id%0d: got %h want %h", g, bus_if.cmd_id, 8'h10 + 8'(exp_order[g])); end
            serve(2 + g, 8'h30 + 8'(g));
            exp_done = 4'b0001 << exp_order[g];
            n_vec++; if (bus_if.req_done !== exp_done) begin n_err++; $display("FAIL rr_done%0d: got %b want %b", g, bus_if.req_done, exp_done); end
            n_vec++; if (bus_if.req_rdata !== 8'h30 + 8'(g)) begin n_err++; $display("FAIL rr_rdata%0d: got %h want %h", g, bus_if.req_rdata, 8'h30 + 8'(g)); end
            @(negedge clk);
            @(negedge clk);
            // requester 0 stays valid after its first turn to come round again
            if (g != 0) bus_if.req_valid[exp_order[g]] = 1'b0;
        end
        repeat (6) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_timeout();
        bit ok;
        int pc0;
        set_req(1, 1'b0, 8'h50, 8'h01, 8'h02);
        bus_if.cmd_rdata = 8'hCC;
        bus_if.req_valid[1] = 1'b1;
        wait_pulse(ok, 8);
        bus_if.req_valid[1] = 1'b0;  // dropping after grant must not cancel
        n_vec++; if ((ok !== 1'b1) || (grant_idx !== 3'd1)) begin n_err++; $display("FAIL to_grant: got ok %b idx %0d want ok 1 idx 1", ok, grant_idx); end
        repeat (16) @(negedge clk);
        n_vec++; if ({busy, bus_if.req_done} !== 5'b1_0000) begin n_err++; $display("FAIL to_early: got %b want 10000", {busy, bus_if.req_done}); end
        @(negedge clk);
        n_vec++; if (bus_if.req_done !== 4'b0010) begin n_err++; $display("FAIL to_done: got %b want 0010", bus_if.req_done); end
        n_vec++; if ({bus_if.req_err, bus_if.req_rdata} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL to_result: got %h want 100", {bus_if.req_err, bus_if.req_rdata}); end
        n_vec++; if (timeout_cnt !== 8'd1) begin n_err++; $display("FAIL to_cnt: got %0d want 1", timeout_cnt); end
        repeat (2) @(negedge clk);
        pc0 = pulse_count;
        bus_if.cmd_cmplt = 1'b1;  // stray, late completion
        bus_if.cmd_rdata = 8'h99;
        @(negedge clk);
        bus_if.cmd_cmplt = 1'b0;
        n_vec++; if ({busy, state_dbg, bus_if.req_done} !== 7'b0_00_0000) begin n_err++; $display("FAIL to_stray: got %b want 0000000", {busy, state_dbg, bus_if.req_done}); end
        repeat (3) @(negedge clk);
        n_vec++; if ({bus_if.req_err, bus_if.req_rdata, timeout_cnt} !== {1'b1, 8'h00, 8'd1}) begin n_err++; $display("FAIL to_hold: got %h want 10001", {bus_if.req_err, bus_if.req_rdata, timeout_cnt}); end
        n_vec++; if (pulse_count - pc0 !== 0) begin n_err++; $display("FAIL to_stray_pulse: got %0d want 0", pulse_count - pc0); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        // completion lands in the timeout cycle
        set_req(3, 1'b1, 8'hA2, 8'h7F, 8'h00);
        bus_if.req_valid[3] = 1'b1;
        wait_pulse(ok, 8);
        n_vec++; if ((ok !== 1'b1) || (grant_idx !== 3'd3)) begin n_err++; $display("FAIL sim_grant: got ok %b idx %0d want ok 1 idx 3", ok, grant_idx); end
        serve(16, 8'h5A);
        bus_if.req_valid[3] = 1'b0;
        n_vec++; if (bus_if.req_done !== 4'b1000) begin n_err++; $display("FAIL sim_done: got %b want 1000", bus_if.req_done); end
        n_vec++; if ({bus_if.req_err, bus_if.req_rdata, timeout_cnt} !== {1'b0, 8'h5A, 8'd1}) begin n_err++; $display("FAIL sim_result: got %h want 05a01", {bus_if.req_err, bus_if.req_rdata, timeout_cnt}); end
        repeat (3) @(negedge clk);
        // late drop with another requester pending
        set_req(1, 1'b0, 8'h61, 8'h00, 8'h00);
        set_req(3, 1'b0, 8'h63, 8'h00, 8'h00);
        bus_if.req_valid[1] = 1'b1;
        wait_pulse(ok, 8);
        serve(2, 8'h00);
        n_vec++; if (bus_if.req_done !== 4'b0010) begin n_err++; $display("FAIL sim_done1: got %b want 0010", bus_if.req_done); end
        bus_if.req_valid[3] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_if.req_valid[1] = 1'b0;
        wait_pulse(ok, 8);
        n_vec++; if ({ok, grant_idx, bus_if.cmd_id} !== {1'b1, 3'd3, 8'h63}) begin n_err++; $display("FAIL sim_other: got %h want %h", {ok, grant_idx, bus_if.cmd_id}, {1'b1, 3'd3, 8'h63}); end
        serve(2, 8'h00);
        bus_if.req_valid[3] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int t0;
        int t1;
        // two requesters pending together: spacing is 4 cycles plus sequencer time
        set_req(0, 1'b0, 8'h70, 8'h00, 8'h00);
        set_req(2, 1'b0, 8'h72, 8'h00, 8'h00);
        bus_if.req_valid = 4'b0101;
        wait_pulse(ok, 8);
        t0 = pulse_count;
        n_vec++; if ({ok, grant_idx} !== {1'b1, 3'd0}) begin n_err++; $display("FAIL b2b_first: got %h want 8", {ok, grant_idx}); end
        serve(1, 8'h00);
        bus_if.req_valid[0] = 1'b0;
        // done is shown now; next pulse exactly 2 cycles later
        @(negedge clk);
        n_vec++; if (bus_if.cmd_pulse !== 1'b0) begin n_err++; $display("FAIL b2b_gap: got %b want 0", bus_if.cmd_pulse); end
        @(negedge clk);
        t1 = pulse_count;
        n_vec++; if ({bus_if.cmd_pulse, grant_idx} !== {1'b1, 3'd2}) begin n_err++; $display("FAIL b2b_second: got %h want a", {bus_if.cmd_pulse, grant_idx}); end
        serve(1, 8'h00);
        bus_if.req_valid[2] = 1'b0;
        n_vec++; if ((bus_if.req_done !== 4'b0100) || (t1 - t0 !== 1)) begin n_err++; $display("FAIL b2b_done: got %b/%0d want 0100/1", bus_if.req_done, t1 - t0); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        set_req(3, 1'b0, 8'h83, 8'h00, 8'h00);
        set_req(0, 1'b0, 8'h80, 8'h00, 8'h00);
        bus_if.req_valid[3] = 1'b1;
        wait_pulse(ok, 8);
        repeat (3) @(negedge clk);
        n_vec++; if (state_dbg !== 2'd2) begin n_err++; $display("FAIL rst_pre_state: got %0d want 2", state_dbg); end
        rst = 1'b1;
        bus_if.req_valid[0] = 1'b1;
        @(negedge clk);
        n_vec++; if ({busy, bus_if.req_done, bus_if.cmd_pulse} !== 6'b0) begin n_err++; $display("FAIL rst_mid: got %b want 000000", {busy, bus_if.req_done, bus_if.cmd_pulse}); end
        n_vec++; if ({timeout_cnt, grant_idx} !== 11'd0) begin n_err++; $display("FAIL rst_mid_regs: got %h want 0", {timeout_cnt, grant_idx}); end
        @(negedge clk);
        n_vec++; if (bus_if.cmd_pulse !== 1'b0) begin n_err++; $display("FAIL rst_hold_pulse: got %b want 0", bus_if.cmd_pulse); end
        rst = 1'b0;
        wait_pulse(ok, 8);
        n_vec++; if ({ok, grant_idx, bus_if.cmd_id} !== {1'b1, 3'd0, 8'h80}) begin n_err++; $display("FAIL rst_next_grant: got %h want %h", {ok, grant_idx, bus_if.cmd_id}, {1'b1, 3'd0, 8'h80}); end
        serve(2, 8'h00);
        bus_if.req_valid[0] = 1'b0;
        n_vec++; if (bus_if.req_done !== 4'b0001) begin n_err++; $display("FAIL rst_next_done: got %b want 0001", bus_if.req_done); end
        bus_if.req_valid[3] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_write();
        test_read();
        test_round_robin();
        test_timeout();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
